// File: rtl/udma_uart_rx_core_if.sv
// Bus bundle between the uDMA UART receiver core and its pad/config/consumer side.
// The master drives the pad line, configuration and ready; the slave is the receiver core.
interface udma_uart_rx_core_if;
    logic        rx_i;
    logic        cfg_en_i;
    logic [15:0] cfg_div_i;
    logic [1:0]  cfg_bits_i;
    logic        cfg_parity_en_i;
    logic        cfg_stop_bits_i;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i;
    logic        rx_char_event_o;
    logic        err_overrun_o;
    logic        err_parity_o;
    logic        err_frame_o;
    logic        busy_o;

    modport master (
        output rx_i, cfg_en_i, cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_stop_bits_i, ready_i,
        input  data_o, valid_o, rx_char_event_o, err_overrun_o, err_parity_o, err_frame_o, busy_o
    );

    modport slave (
        input  rx_i, cfg_en_i, cfg_div_i, cfg_bits_i, cfg_parity_en_i, cfg_stop_bits_i, ready_i,
        output data_o, valid_o, rx_char_event_o, err_overrun_o, err_parity_o, err_frame_o, busy_o
    );
endinterface

// File: rtl/udma_uart_rx_core.sv
// UART receiver for the uDMA RX channel: synchronized pad line, mid-bit sampling,
// 5..8 data bits, optional even parity, 1 or 2 stop bits, single-entry output buffer.
module udma_uart_rx_core (
    input  logic                    sys_clk_i,
    input  logic                    rst_i,
    udma_uart_rx_core_if.slave      bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Even parity check over the zero-extended data and the received parity bit.
    function automatic logic parity_mismatch(input logic [7:0] data, input logic pbit);
        return ^{data, pbit};
    endfunction

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [7:0]  shift_r;
    logic [2:0]  bit_idx_r;
    logic        stop_idx_r;
    logic        parity_bad_r;
    logic        frame_err_r;
    logic [1:0]  sync_r;
    logic        rx_prev_r;
    logic [7:0]  data_r;
    logic        valid_r;
    logic        evt_r;
    logic        ovr_r;
    logic        perr_r;
    logic        ferr_r;
    logic        busy_r;

    logic        rx_s;
    logic        bit_tick_s;
    logic        half_tick_s;
    logic        last_data_s;
    logic        last_stop_s;
    logic        frame_bad_s;
    logic        handshake_s;

    // Comparisons use >= so a mid-frame cfg change can never strand the counter.
    assign rx_s        = sync_r[1];
    assign bit_tick_s  = (cnt_r >= bus.cfg_div_i);
    assign half_tick_s = (cnt_r >= {1'b0, bus.cfg_div_i[15:1]});
    assign last_data_s = (bit_idx_r == ({1'b0, bus.cfg_bits_i} + 3'd4));
    assign last_stop_s = (stop_idx_r == bus.cfg_stop_bits_i);
    assign frame_bad_s = frame_err_r | ~rx_s;
    assign handshake_s = valid_r & bus.ready_i;

    assign bus.data_o          = data_r;
    assign bus.valid_o         = valid_r;
    assign bus.rx_char_event_o = evt_r;
    assign bus.err_overrun_o   = ovr_r;
    assign bus.err_parity_o    = perr_r;
    assign bus.err_frame_o     = ferr_r;
    assign bus.busy_o          = busy_r;

    // Two-flop synchronizer on the pad line plus previous-sample register for edge detection.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b0;
        end else begin
            sync_r    <= {sync_r[0], bus.rx_i};
            rx_prev_r <= rx_s;
        end
    end

    // Receive FSM, baud counter, shift register and registered output buffer/pulses.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= IDLE;
            cnt_r        <= 16'd0;
            shift_r      <= 8'd0;
            bit_idx_r    <= 3'd0;
            stop_idx_r   <= 1'b0;
            parity_bad_r <= 1'b0;
            frame_err_r  <= 1'b0;
            data_r       <= 8'd0;
            valid_r      <= 1'b0;
            evt_r        <= 1'b0;
            ovr_r        <= 1'b0;
            perr_r       <= 1'b0;
            ferr_r       <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            evt_r  <= 1'b0;
            ovr_r  <= 1'b0;
            perr_r <= 1'b0;
            ferr_r <= 1'b0;
            if (handshake_s) begin
                valid_r <= 1'b0;
            end
            if (!bus.cfg_en_i) begin
                state_r <= IDLE;
                cnt_r   <= 16'd0;
                busy_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        cnt_r <= 16'd0;
                        if (!rx_s && rx_prev_r) begin
                            state_r      <= START;
                            busy_r       <= 1'b1;
                            shift_r      <= 8'd0;
                            bit_idx_r    <= 3'd0;
                            stop_idx_r   <= 1'b0;
                            parity_bad_r <= 1'b0;
                            frame_err_r  <= 1'b0;
                        end
                    end
                    START: begin
                        if (half_tick_s) begin
                            cnt_r <= 16'd0;
                            if (!rx_s) begin
                                state_r <= DATA;
                            end else begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    DATA: begin
                        if (bit_tick_s) begin
                            cnt_r              <= 16'd0;
                            shift_r[bit_idx_r] <= rx_s;
                            if (last_data_s) begin
                                state_r <= bus.cfg_parity_en_i ? PARITY : STOP;
                            end else begin
                                bit_idx_r <= bit_idx_r + 3'd1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    PARITY: begin
                        if (bit_tick_s) begin
                            cnt_r        <= 16'd0;
                            parity_bad_r <= parity_mismatch(shift_r, rx_s);
                            state_r      <= STOP;
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    STOP: begin
                        if (bit_tick_s) begin
                            cnt_r       <= 16'd0;
                            frame_err_r <= frame_bad_s;
                            if (last_stop_s) begin
                                state_r <= IDLE;
                                busy_r  <= 1'b0;
                                if (frame_bad_s) begin
                                    ferr_r <= 1'b1;
                                end else begin
                                    perr_r <= parity_bad_r;
                                    if (!valid_r || bus.ready_i) begin
                                        data_r  <= shift_r;
                                        valid_r <= 1'b1;
                                        evt_r   <= 1'b1;
                                    end else begin
                                        ovr_r <= 1'b1;
                                    end
                                end
                            end else begin
                                stop_idx_r <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r + 16'd1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= 16'd0;
                        busy_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_udma_uart_rx_core.sv
// Directed bench for udma_uart_rx_core: a frame-level model predicts the completion cycle
// and outcome of every character and is compared against the DUT outputs each cycle.
module tb_udma_uart_rx_core;

    logic clk;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    udma_uart_rx_core_if bus_if ();

    udma_uart_rx_core dut (
        .sys_clk_i (clk),
        .rst_i     (rst),
        .bus       (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         done;
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } frame_t;

    frame_t     exp_q[$];
    logic       m_valid = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic       m_evt = 1'b0, m_ovr = 1'b0, m_par = 1'b0, m_frm = 1'b0;
    int         n_evt = 0, n_ovr = 0, n_par = 0, n_frm = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model: at each edge apply handshake and any frame completing on that edge; compare at negedge.
    initial begin
        logic   v_old;
        logic   rdy;
        frame_t f;
        forever begin
            @(posedge clk);
            cyc++;
            rdy = bus_if.ready_i;
            if (!rst) begin
                v_old = m_valid;
                m_evt = 1'b0; m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0;
                if (v_old && rdy) m_valid = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].done == cyc) begin
                    f = exp_q.pop_front();
                    if (f.ferr) begin
                        m_frm = 1'b1;
                    end else begin
                        m_par = f.perr;
                        if (!v_old || rdy) begin
                            m_data  = f.d;
                            m_valid = 1'b1;
                            m_evt   = 1'b1;
                        end else begin
                            m_ovr = 1'b1;
                        end
                    end
                end
            end
            @(negedge clk);
            if (rst) begin
                m_valid = 1'b0; m_data = 8'd0;
                m_evt = 1'b0; m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0;
                exp_q.delete();
                check("rst_busy", {31'd0, bus_if.busy_o}, 32'd0);
            end
            check("valid_o", {31'd0, bus_if.valid_o}, {31'd0, m_valid});
            check("data_o", {24'd0, bus_if.data_o}, {24'd0, m_data});
            check("rx_char_event_o", {31'd0, bus_if.rx_char_event_o}, {31'd0, m_evt});
            check("err_overrun_o", {31'd0, bus_if.err_overrun_o}, {31'd0, m_ovr});
            check("err_parity_o", {31'd0, bus_if.err_parity_o}, {31'd0, m_par});
            check("err_frame_o", {31'd0, bus_if.err_frame_o}, {31'd0, m_frm});
            n_evt += int'(bus_if.rx_char_event_o);
            n_ovr += int'(bus_if.err_overrun_o);
            n_par += int'(bus_if.err_parity_o);
            n_frm += int'(bus_if.err_frame_o);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Send one frame with the current cfg; cut>0 abandons the frame after that many cycles.
    task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic bad_stop,
                              input int cut);
        int         nb;
        int         idx;
        int         div;
        int         spent;
        logic [11:0] bits;
        logic [7:0] dm;
        frame_t     f;
        nb  = int'(bus_if.cfg_bits_i) + 5;
        div = int'(bus_if.cfg_div_i);
        dm  = 8'd0;
        for (int i = 0; i < nb; i++) dm[i] = d[i];
        bits    = 12'hFFF;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1 + i] = dm[i];
        idx = 1 + nb;
        if (bus_if.cfg_parity_en_i) begin
            bits[idx] = (^dm) ^ bad_par;
            idx++;
        end
        bits[idx] = ~bad_stop;
        idx++;
        if (bus_if.cfg_stop_bits_i) begin
            bits[idx] = 1'b1;
            idx++;
        end
        // Start falls before edge cyc+1; two sync edges, one detect edge, half-bit, then idx-1 bit periods.
        f.done = cyc + 4 + (div >> 1) + (div + 1) * (idx - 1);
        f.d    = dm;
        f.perr = bus_if.cfg_parity_en_i & bad_par;
        f.ferr = bad_stop;
        if (cut == 0) exp_q.push_back(f);
        spent = 0;
        for (int b = 0; b < idx; b++) begin
            bus_if.rx_i = bits[b];
            for (int c = 0; c <= div; c++) begin
                @(posedge clk);
                #1;
                spent++;
                if (cut != 0 && spent >= cut) return;
            end
        end
        bus_if.rx_i = 1'b1;
    endtask

    initial begin
        int e0, o0, p0, f0;
        bus_if.rx_i            = 1'b1;
        bus_if.cfg_en_i        = 1'b1;
        bus_if.cfg_div_i       = 16'd3;
        bus_if.cfg_bits_i      = 2'd3;
        bus_if.cfg_parity_en_i = 1'b0;
        bus_if.cfg_stop_bits_i = 1'b0;
        bus_if.ready_i         = 1'b1;
        rst = 1'b1;
        idle(3);
        check("reset_data", {24'd0, bus_if.data_o}, 32'd0);
        check("reset_valid", {31'd0, bus_if.valid_o}, 32'd0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5, consumer always ready
        e0 = n_evt; o0 = n_ovr; p0 = n_par; f0 = n_frm;
        send_frame(8'hA5, 1'b0, 1'b0, 0);
        idle(6);
        check("a5_data", {24'd0, bus_if.data_o}, 32'h0000_00A5);
        check("a5_events", n_evt - e0, 32'd1);
        check("a5_errors", (n_ovr - o0) + (n_par - p0) + (n_frm - f0), 32'd0);
        check("a5_consumed", {31'd0, bus_if.valid_o}, 32'd0);

        // 5 bits, even parity, 2 stops: bad parity then good parity
        bus_if.cfg_bits_i = 2'd0; bus_if.cfg_parity_en_i = 1'b1; bus_if.cfg_stop_bits_i = 1'b1;
        e0 = n_evt; p0 = n_par;
        send_frame(8'h15, 1'b1, 1'b0, 0);
        idle(6);
        check("par_data", {24'd0, bus_if.data_o}, 32'h0000_0015);
        check("par_err", n_par - p0, 32'd1);
        send_frame(8'h0A, 1'b0, 1'b0, 0);
        idle(6);
        check("par_ok_data", {24'd0, bus_if.data_o}, 32'h0000_000A);
        check("par_ok_counts", ((n_evt - e0) << 8) | (n_par - p0), 32'h0000_0201);

        // Overrun: consumer stalled across two back-to-back 8N1 frames
        bus_if.cfg_bits_i = 2'd3; bus_if.cfg_parity_en_i = 1'b0; bus_if.cfg_stop_bits_i = 1'b0;
        bus_if.ready_i = 1'b0;
        e0 = n_evt; o0 = n_ovr;
        send_frame(8'h11, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b0, 1'b0, 0);
        idle(6);
        check("ovr_data", {24'd0, bus_if.data_o}, 32'h0000_0011);
        check("ovr_valid", {31'd0, bus_if.valid_o}, 32'd1);
        check("ovr_pulses", ((n_evt - e0) << 8) | (n_ovr - o0), 32'h0000_0101);
        bus_if.ready_i = 1'b1;
        idle(3);
        check("ovr_drained", {31'd0, bus_if.valid_o}, 32'd0);

        // Frame error: stop bit low on 0x3C
        e0 = n_evt; f0 = n_frm;
        send_frame(8'h3C, 1'b0, 1'b1, 0);
        idle(10);
        check("frm_err", n_frm - f0, 32'd1);
        check("frm_no_event", n_evt - e0, 32'd0);
        check("frm_busy", {31'd0, bus_if.busy_o}, 32'd0);

        // Glitch rejection with div=7: low pulse of (7>>1)-1 = 2 cycles
        bus_if.cfg_div_i = 16'd7;
        idle(4);
        e0 = n_evt; o0 = n_ovr; p0 = n_par; f0 = n_frm;
        bus_if.rx_i = 1'b0;
        idle(2);
        bus_if.rx_i = 1'b1;
        idle(100);
        check("glitch_busy", {31'd0, bus_if.busy_o}, 32'd0);
        check("glitch_quiet", (n_evt - e0) + (n_ovr - o0) + (n_par - p0) + (n_frm - f0), 32'd0);

        // 7-bit character at div=7
        bus_if.cfg_bits_i = 2'd2;
        send_frame(8'hAB, 1'b0, 1'b0, 0);
        idle(10);
        check("seven_bit_data", {24'd0, bus_if.data_o}, 32'h0000_002B);

        // Reset in DATA state, then a clean 0x5A
        bus_if.cfg_div_i = 16'd3; bus_if.cfg_bits_i = 2'd3;
        e0 = n_evt;
        send_frame(8'h77, 1'b0, 1'b0, 20);
        rst = 1'b1;
        bus_if.rx_i = 1'b1;
        idle(2);
        check("rst_mid_busy", {31'd0, bus_if.busy_o}, 32'd0);
        rst = 1'b0;
        idle(4);
        send_frame(8'h5A, 1'b0, 1'b0, 0);
        idle(6);
        check("after_rst_data", {24'd0, bus_if.data_o}, 32'h0000_005A);
        check("after_rst_events", n_evt - e0, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
